// File: rtl/special_move_pkg.sv
// Shared types for the Mini SRC special-register move sequencer: FSM states,
// move kinds, the control-strobe bundle and the opcode decoder.
package special_move_pkg;

  localparam int unsigned OpcW = 5;

  localparam logic [OpcW-1:0] OpMfhiDef = 5'b11000;
  localparam logic [OpcW-1:0] OpMfloDef = 5'b11001;
  localparam logic [OpcW-1:0] OpMthiDef = 5'b11010;
  localparam logic [OpcW-1:0] OpMtloDef = 5'b11011;

  typedef enum logic [2:0] {
    StIdle, StT0, StT1, StT2, StDec, StExec, StDone, StErr
  } state_e;

  typedef enum logic [2:0] {
    MvHiToR, MvLoToR, MvRToHi, MvRToLo, MvIllegal
  } move_e;

  typedef struct packed {
    logic pc_out, mar_in, inc_pc, z_in;
    logic zlow_out, pc_in, read, mdr_in;
    logic mdr_out, ir_in;
    logic gra, rin, rout, hi_in, lo_in, hi_out, lo_out;
  } ctrl_t;

  function automatic move_e decode_move(input logic [OpcW-1:0] opc,
                                        input logic [OpcW-1:0] op_mfhi = OpMfhiDef,
                                        input logic [OpcW-1:0] op_mflo = OpMfloDef,
                                        input logic [OpcW-1:0] op_mthi = OpMthiDef,
                                        input logic [OpcW-1:0] op_mtlo = OpMtloDef);
    if (opc == op_mfhi) return MvHiToR;
    if (opc == op_mflo) return MvLoToR;
    if (opc == op_mthi) return MvRToHi;
    if (opc == op_mtlo) return MvRToLo;
    return MvIllegal;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Per-state cycle counter; restarts on every state change and saturates at the
// memory-timeout limit so it never wraps while parked in IDLE or ERR.
module step_timer #(
  parameter int unsigned STEP_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic clr,
  input  logic restart,
  output logic step_last,
  output logic in_step,
  output logic to_expired
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] StepLast = CntW'(STEP_CYCLES - 1);
  localparam logic [CntW-1:0] ToLast   = CntW'(MEM_TIMEOUT - 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (restart) begin
      count_d = '0;
    end else if (count_q != ToLast) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) count_q <= '0;
    else      count_q <= count_d;
  end

  assign step_last  = (count_q == StepLast);
  assign in_step    = (count_q <= StepLast);
  assign to_expired = (count_q == ToLast);

endmodule

// File: rtl/special_move_sequencer.sv
// Hardwired Mini SRC sequencer: fetch (T0-T2), decode, then one of mfhi/mflo/mthi/mtlo.
// All outputs are registered from the current state, so they trail the state by one cycle.
module special_move_sequencer
  import special_move_pkg::*;
#(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       OPC_W       = 5,
  parameter logic [OPC_W-1:0]  OP_MFHI     = 5'b11000,
  parameter logic [OPC_W-1:0]  OP_MFLO     = 5'b11001,
  parameter logic [OPC_W-1:0]  OP_MTHI     = 5'b11010,
  parameter logic [OPC_W-1:0]  OP_MTLO     = 5'b11011,
  parameter int unsigned       STEP_CYCLES = 2,
  parameter int unsigned       MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [DATA_W-1:0] ir_data,
  input  logic              mem_ready,
  output logic PC_out, output logic MAR_in, output logic IncPC, output logic Z_in,
  output logic Zlow_out, output logic PC_in, output logic Read, output logic MDR_in,
  output logic MDR_out, output logic IR_in,
  output logic Gra, output logic Rin, output logic Rout,
  output logic HI_in, output logic LO_in, output logic HI_out, output logic LO_out,
  output logic busy,
  output logic done,
  output logic illegal,
  output logic timeout
);

  state_e           state_q, state_d;
  logic [OPC_W-1:0] op_q, op_d;
  logic             ready_seen_q, ready_seen_d;
  logic             illegal_q, illegal_d, timeout_q, timeout_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             step_last, in_step, to_expired;
  logic [OPC_W-1:0] ir_opc;
  move_e            exec_move;
  logic             unused_ir;

  assign ir_opc    = ir_data[DATA_W-1 -: OPC_W];
  assign unused_ir = ^ir_data[DATA_W-OPC_W-1:0];
  assign exec_move = decode_move(op_q, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO);

  step_timer #(
    .STEP_CYCLES(STEP_CYCLES),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_step_timer (
    .clk       (clk),
    .clr       (clr),
    .restart   (state_d != state_q),
    .step_last (step_last),
    .in_step   (in_step),
    .to_expired(to_expired)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    ready_seen_d = 1'b0;
    illegal_d    = illegal_q;
    timeout_d    = timeout_q;
    unique case (state_q)
      StIdle: if (start) state_d = StT0;
      StT0:   if (step_last) state_d = StT1;
      StT1: begin
        ready_seen_d = ready_seen_q | mem_ready;
        // A ready arriving on the final allowed cycle still wins over the timeout.
        if ((step_last || !in_step) && (ready_seen_q || mem_ready)) begin
          state_d = StT2;
        end else if (to_expired) begin
          state_d   = StErr;
          timeout_d = 1'b1;
        end
      end
      StT2:   if (step_last) state_d = StDec;
      StDec: begin
        op_d = ir_opc;
        if (decode_move(ir_opc, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO) == MvIllegal) begin
          state_d   = StErr;
          illegal_d = 1'b1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: if (step_last) state_d = StDone;
      StDone: state_d = StIdle;
      StErr:  state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ctrl_d = '0;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_q)
      StT0: begin
        ctrl_d.pc_out = 1'b1;
        ctrl_d.mar_in = 1'b1;
        ctrl_d.inc_pc = 1'b1;
        ctrl_d.z_in   = 1'b1;
        busy_d        = 1'b1;
      end
      StT1: begin
        ctrl_d.zlow_out = in_step;
        ctrl_d.pc_in    = in_step;
        ctrl_d.read     = 1'b1;
        ctrl_d.mdr_in   = 1'b1;
        busy_d          = 1'b1;
      end
      StT2: begin
        ctrl_d.mdr_out = 1'b1;
        ctrl_d.ir_in   = 1'b1;
        busy_d         = 1'b1;
      end
      StDec: busy_d = 1'b1;
      StExec: begin
        ctrl_d.gra = 1'b1;
        busy_d     = 1'b1;
        unique case (exec_move)
          MvHiToR: begin ctrl_d.rin  = 1'b1; ctrl_d.hi_out = 1'b1; end
          MvLoToR: begin ctrl_d.rin  = 1'b1; ctrl_d.lo_out = 1'b1; end
          MvRToHi: begin ctrl_d.rout = 1'b1; ctrl_d.hi_in  = 1'b1; end
          MvRToLo: begin ctrl_d.rout = 1'b1; ctrl_d.lo_in  = 1'b1; end
          default: ;
        endcase
      end
      StDone: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q      <= StIdle;
      op_q         <= '0;
      ready_seen_q <= 1'b0;
      illegal_q    <= 1'b0;
      timeout_q    <= 1'b0;
      ctrl_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      ready_seen_q <= ready_seen_d;
      illegal_q    <= illegal_d;
      timeout_q    <= timeout_d;
      ctrl_q       <= ctrl_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign PC_out   = ctrl_q.pc_out;
  assign MAR_in   = ctrl_q.mar_in;
  assign IncPC    = ctrl_q.inc_pc;
  assign Z_in     = ctrl_q.z_in;
  assign Zlow_out = ctrl_q.zlow_out;
  assign PC_in    = ctrl_q.pc_in;
  assign Read     = ctrl_q.read;
  assign MDR_in   = ctrl_q.mdr_in;
  assign MDR_out  = ctrl_q.mdr_out;
  assign IR_in    = ctrl_q.ir_in;
  assign Gra      = ctrl_q.gra;
  assign Rin      = ctrl_q.rin;
  assign Rout     = ctrl_q.rout;
  assign HI_in    = ctrl_q.hi_in;
  assign LO_in    = ctrl_q.lo_in;
  assign HI_out   = ctrl_q.hi_out;
  assign LO_out   = ctrl_q.lo_out;
  assign busy     = busy_q;
  assign done     = done_q;
  assign illegal  = illegal_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_special_move_sequencer.sv
// Self-checking bench: builds the expected per-cycle strobe trace from the phase
// lengths of each instruction and compares it cycle by cycle against the sequencer.
module tb_special_move_sequencer;

  localparam int S  = 2;
  localparam int TO = 15;

  typedef logic [18:0] vec_t;
  localparam vec_t BSY   = 19'h40000;
  localparam vec_t DNE   = 19'h20000;
  localparam vec_t T0M   = 19'h1E000;
  localparam vec_t ZLPI  = 19'h01800;
  localparam vec_t RDMI  = 19'h00600;
  localparam vec_t T2M   = 19'h00180;
  localparam vec_t GRA   = 19'h00040;
  localparam vec_t RIN   = 19'h00020;
  localparam vec_t ROUT  = 19'h00010;
  localparam vec_t HIIN  = 19'h00008;
  localparam vec_t LOIN  = 19'h00004;
  localparam vec_t HIOUT = 19'h00002;
  localparam vec_t LOOUT = 19'h00001;
  localparam vec_t DRV   = 19'h11113;

  logic clk = 1'b0;
  logic clr, start, mem_ready;
  logic [31:0] ir_data;
  logic PC_out, MAR_in, IncPC, Z_in, Zlow_out, PC_in, Read, MDR_in, MDR_out, IR_in;
  logic Gra, Rin, Rout, HI_in, LO_in, HI_out, LO_out, busy, done, illegal, timeout;
  vec_t obs;

  int   vectors = 0;
  int   miscompares = 0;
  int   done_at;
  vec_t exp_q[$];
  bit   exp_ill, exp_to;

  always #5 clk = ~clk;

  special_move_sequencer dut (
    .clk(clk), .clr(clr), .start(start), .ir_data(ir_data), .mem_ready(mem_ready),
    .PC_out(PC_out), .MAR_in(MAR_in), .IncPC(IncPC), .Z_in(Z_in),
    .Zlow_out(Zlow_out), .PC_in(PC_in), .Read(Read), .MDR_in(MDR_in),
    .MDR_out(MDR_out), .IR_in(IR_in),
    .Gra(Gra), .Rin(Rin), .Rout(Rout), .HI_in(HI_in), .LO_in(LO_in),
    .HI_out(HI_out), .LO_out(LO_out),
    .busy(busy), .done(done), .illegal(illegal), .timeout(timeout)
  );

  assign obs = {busy, done, PC_out, MAR_in, IncPC, Z_in, Zlow_out, PC_in, Read, MDR_in,
                MDR_out, IR_in, Gra, Rin, Rout, HI_in, LO_in, HI_out, LO_out};

  a_bus_onehot: assert property (@(negedge clk) $onehot0(obs & DRV))
    else $error("FAIL bus_onehot drivers=%h", obs & DRV);

  // Reference: one instruction as a list of per-cycle strobe groups.
  // r = first T1 cycle with mem_ready high (negative: never).
  function automatic void push_instr(input logic [31:0] w, input int r);
    int   t1_len;
    vec_t mv;
    repeat (S) exp_q.push_back(BSY | T0M);
    if (r >= 0 && r <= TO - 1) t1_len = (r + 1 > S) ? r + 1 : S;
    else                       t1_len = TO;
    for (int j = 0; j < t1_len; j++) exp_q.push_back(BSY | RDMI | ((j < S) ? ZLPI : '0));
    if (!(r >= 0 && r <= TO - 1)) begin
      exp_to = 1'b1;
      return;
    end
    repeat (S) exp_q.push_back(BSY | T2M);
    exp_q.push_back(BSY);
    case (w[31:27])
      5'b11000: mv = RIN | HIOUT;
      5'b11001: mv = RIN | LOOUT;
      5'b11010: mv = ROUT | HIIN;
      5'b11011: mv = ROUT | LOIN;
      default:  mv = '0;
    endcase
    if (mv == '0) begin
      exp_ill = 1'b1;
      return;
    end
    repeat (S) exp_q.push_back(BSY | GRA | mv);
    exp_q.push_back(BSY | DNE);
  endfunction

  task automatic do_reset();
    clr = 1'b0; start = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    exp_ill = 1'b0; exp_to = 1'b0;
    exp_q.delete();
  endtask

  // Pulse (or hold) start, then compare every cycle against exp_q (lagged by one).
  task automatic run_check(input int r, input bit pulse, input bit hold, input int extra,
                           input string name);
    int   n;
    vec_t e;
    n = exp_q.size();
    done_at = -1;
    @(negedge clk);
    start = 1'b1; mem_ready = 1'b0;
    @(posedge clk);
    for (int k = 0; k < n + 1 + extra; k++) begin
      @(negedge clk);
      start     = hold;
      mem_ready = (r >= 0) && (pulse ? (k == S + r) : (k >= S + r));
      e = (k == 0 || k - 1 >= n) ? '0 : exp_q[k-1];
      if (done === 1'b1 && done_at < 0) done_at = k;
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got %h want %h", name, k, obs, e);
      end
      vectors++;
      if ($countones(obs & DRV) > 1) begin
        miscompares++;
        $display("FAIL %s_onehot cycle %0d: drivers %h", name, k, obs & DRV);
      end
    end
    vectors++;
    if ({illegal, timeout} !== {exp_ill, exp_to}) begin
      miscompares++;
      $display("FAIL %s_flags: got ill=%b to=%b want ill=%b to=%b", name, illegal, timeout,
               exp_ill, exp_to);
    end
  endtask

  task automatic test_reset();
    clr = 1'b0; start = 1'b1; mem_ready = 1'b1; ir_data = 32'hC2000000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({obs, illegal, timeout} !== '0) begin
      miscompares++;
      $display("FAIL reset_hold: got %h want 0", {obs, illegal, timeout});
    end
    start = 1'b0; clr = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({obs, illegal, timeout} !== '0) begin
      miscompares++;
      $display("FAIL reset_idle: got %h want 0", {obs, illegal, timeout});
    end
  endtask

  task automatic test_moves();
    logic [31:0] words [4] = '{32'hC2000000, 32'hCA000000, 32'hD2000000, 32'hDA000000};
    for (int i = 0; i < 4; i++) begin
      do_reset();
      ir_data = words[i];
      push_instr(words[i], 0);
      run_check(0, 1'b0, 1'b0, 3, "move");
      if (i == 0) begin
        vectors++;
        if (done_at !== 4 * S + 2) begin
          miscompares++;
          $display("FAIL mfhi_latency: done at cycle %0d want %0d", done_at, 4 * S + 2);
        end
      end
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    ir_data = 32'hCA000000;
    push_instr(ir_data, 5);
    run_check(5, 1'b0, 1'b0, 2, "mem_wait");
    do_reset();
    ir_data = 32'hDA000000;
    push_instr(ir_data, 0);
    run_check(0, 1'b1, 1'b0, 2, "ready_pulse");
  endtask

  task automatic test_timeout();
    do_reset();
    ir_data = 32'hC2000000;
    push_instr(ir_data, -1);
    run_check(-1, 1'b0, 1'b0, 2, "timeout");
    start = 1'b1; mem_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if ({obs, timeout} !== {19'h0, 1'b1}) begin
        miscompares++;
        $display("FAIL err_ignores_start: got %h want %h", {obs, timeout}, {19'h0, 1'b1});
      end
    end
    start = 1'b0;
  endtask

  task automatic test_illegal();
    do_reset();
    ir_data = 32'h00000000;
    push_instr(ir_data, 0);
    run_check(0, 1'b0, 1'b0, 4, "illegal");
    vectors++;
    if (done_at !== -1) begin
      miscompares++;
      $display("FAIL illegal_done: done seen at %0d want never", done_at);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    ir_data = 32'hC2000000;
    @(negedge clk);
    start = 1'b1; mem_ready = 1'b0;
    @(posedge clk);
    for (int k = 0; k <= S + 1; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    clr = 1'b0;
    @(negedge clk);
    vectors++;
    if ({obs, illegal, timeout} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got %h want 0", {obs, illegal, timeout});
    end
    clr = 1'b1;
    ir_data = 32'hD2000000;
    push_instr(ir_data, 1);
    run_check(1, 1'b0, 1'b0, 2, "after_reset");
  endtask

  task automatic test_back_to_back();
    do_reset();
    ir_data = 32'hDA000000;
    push_instr(ir_data, 0);
    exp_q.push_back('0);
    push_instr(ir_data, 0);
    run_check(0, 1'b0, 1'b1, 0, "back_to_back");
    start = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] w;
    int          sel, rr, r;
    bit          pulse;
    do_reset();
    for (int it = 0; it < 16; it++) begin
      if (exp_ill || exp_to) do_reset();
      exp_q.delete();
      sel = $urandom_range(0, 4);
      if (sel < 4) w = {5'b11000 + 5'(sel), 27'($urandom)};
      else         w = {5'($urandom_range(0, 23)), 27'($urandom)};
      rr    = $urandom_range(0, 19);
      r     = (rr == 19) ? -1 : rr;
      pulse = 1'($urandom_range(0, 1));
      ir_data = w;
      push_instr(w, r);
      run_check(r, pulse, 1'b0, 2, "random");
    end
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; mem_ready = 1'b0; ir_data = '0;
    test_reset();
    test_moves();
    test_mem_wait();
    test_timeout();
    test_illegal();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/special_move_sequencer.md
Name: special_move_sequencer

Overview:
- Hardwired control sequencer for the Mini SRC datapath. It runs the instruction fetch (T0–T2), then executes one special-register move: mfhi, mflo, mthi or mtlo.
- It drives the same datapath control strobes the bench currently toggles by hand.
- It generalises that fixed sequence with four parametrised moves, a configurable step width, a memory-ready handshake with timeout, and an illegal-opcode trap.

Parameters:
- DATA_W, 32, width of ir_data.
- OPC_W, 5, opcode field width; the field is ir_data[DATA_W-1 -: OPC_W].
- OP_MFHI, 5'b11000, opcode for mfhi.
- OP_MFLO, 5'b11001, opcode for mflo.
- OP_MTHI, 5'b11010, opcode for mthi.
- OP_MTLO, 5'b11011, opcode for mtlo.
- STEP_CYCLES, 2, clocks each T-step strobe group is held (≥1).
- MEM_TIMEOUT, 15, maximum T1 cycles waiting for mem_ready (≥STEP_CYCLES).

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  synchronous reset, active-low
- start  in  1  request execution of one instruction
- ir_data  in  DATA_W  current IR contents from the datapath
- mem_ready  in  1  memory read data valid on Mdatain
- PC_out, MAR_in, IncPC, Z_in  out  1 each  T0 strobes
- Zlow_out, PC_in, Read, MDR_in  out  1 each  T1 strobes
- MDR_out, IR_in  out  1 each  T2 strobes
- Gra, Rin, Rout, HI_in, LO_in, HI_out, LO_out  out  1 each  execute strobes
- busy  out  1  high from T0 through DONE inclusive
- done  out  1  one-cycle pulse on completion
- illegal  out  1  sticky: undefined opcode decoded
- timeout  out  1  sticky: mem_ready not seen within MEM_TIMEOUT

Behaviour:
- Clock and reset: one clock, clk. clr is synchronous and active-low.
  - On clr=0 at a rising edge: state=IDLE; all strobes, busy, done, illegal and timeout are 0; counters are 0.
  - Reset overrides every state, including mid-T1 and ERR.
- Outputs: all registered (Moore), decoded from the state and step counter. No combinational path from any input to any output.
- States: IDLE, T0, T1, T2, DEC, EXEC, DONE, ERR.
- IDLE: all strobes 0. start=1 sampled → T0 next cycle, so the first PC_out is visible one cycle after the start edge. start is ignored in every other state.
- T0: PC_out=MAR_in=IncPC=Z_in=1 for exactly STEP_CYCLES cycles, then → T1.
- T1:
  - Zlow_out=PC_in=1 for the first STEP_CYCLES cycles only.
  - Read=MDR_in=1 for the whole state.
  - mem_ready is latched into ready_seen each cycle.
  - Exit to T2 once cycle count ≥ STEP_CYCLES and ready_seen (or mem_ready this cycle).
  - If the count reaches MEM_TIMEOUT with no ready → ERR, timeout=1.
- T2: MDR_out=IR_in=1 for STEP_CYCLES cycles, then → DEC.
- DEC: one cycle with all strobes 0. The opcode field of ir_data is latched into op_q.
  - Match → EXEC.
  - No match → ERR, illegal=1.
- EXEC: Gra=1 for STEP_CYCLES cycles, plus the move-specific strobes:
  - mfhi: Rin, HI_out.
  - mflo: Rin, LO_out.
  - mthi: Rout, HI_in.
  - mtlo: Rout, LO_in.
  - Exactly one bus driver and one load target are active.
  - Then → DONE.
- DONE: done=1 for one cycle, all strobes 0 → IDLE.
- ERR: all strobes 0, busy=0. Remains in ERR until clr=0; start is ignored.
- Latency with ready on the first T1 cycle: 4·STEP_CYCLES + 2 cycles from the first T0 cycle to DONE. With STEP_CYCLES=2, done is seen at the 11th cycle after the start edge.
- Mutual exclusion: at most one of PC_out, Zlow_out, MDR_out, HI_out, LO_out, Rout is high in any cycle.

Decomposition:
- Package special_move_pkg:
  - state enum (3-bit).
  - default opcode localparams.
  - control-bundle struct grouping the strobes.
  - function decode_move(opcode) returning a move enum {MV_HI_TO_R, MV_LO_TO_R, MV_R_TO_HI, MV_R_TO_LO, MV_ILLEGAL}.
- Sub-module step_timer: a loadable down/up counter.
  - Inputs: clr, restart.
  - Outputs: step_last, i.e. count==STEP_CYCLES-1, and to_expired, i.e. count==MEM_TIMEOUT-1.
  - Shared by all states.

Test Plan:
- mfhi: clr=0 for 2 cycles, release; start pulse; ir_data=32'hC2000000; mem_ready=1 in the first T1 cycle → strobe trace matches T0/T1/T2/DEC/EXEC with 2-cycle groups. EXEC shows Gra,Rin,HI_out. done is high exactly at cycle 11 after start; R4 receives HI=0x0FF00FF0 in the datapath.
- mflo and mthi: ir_data=32'hCA000000 → EXEC asserts LO_out+Rin. ir_data=32'hD2000000 → EXEC asserts Rout+HI_in. Both complete with done.
- Memory wait: mem_ready held low for 5 T1 cycles, then high → T1 lasts 6 cycles and Zlow_out/PC_in drop after 2. With mem_ready never high → timeout=1 after 15 T1 cycles, then ERR, no strobes, start ignored until clr.
- Illegal: ir_data=32'h00000000 → DEC → ERR; illegal=1; no EXEC strobes; done never pulses.
- Reset mid-operation: clr=0 during the second T1 cycle → next cycle all outputs 0, state IDLE. A new start then executes normally.
- Protocol checks: start held high continuously → instructions run back-to-back with exactly one IDLE cycle between done and the next T0. An assertion checks one-hot bus drivers every cycle.
